// File: rtl/l1_mem_arbiter_pkg.sv
// Shared constants for the L1 line-fill arbiter: widths, FSM state codes, grant IDs.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie breaking (see l1_mem_arbiter_arb_pick).
package l1_mem_arbiter_pkg;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam int OFFS_W = 5;

  localparam logic [1:0] ARB_IDLE     = 2'd0;
  localparam logic [1:0] ARB_MEM_WAIT = 2'd1;
  localparam logic [1:0] ARB_RESP     = 2'd2;

  localparam logic GNT_IC = 1'b0;
  localparam logic GNT_DC = 1'b1;

  // Memory works on whole lines, so the byte offset is always cleared.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/l1_mem_arbiter_arb_pick.sv
// Combinational winner select between icache and dcache line requests.
// ARB_ROUND_ROBIN_EN defined: ties go to the requester that did not win last; otherwise dcache wins ties.
module l1_mem_arbiter_arb_pick
  import l1_mem_arbiter_pkg::*;
(
  input  logic ic_req,
  input  logic dc_req,
  input  logic last_grant,
  output logic any_req,
  output logic grant
);

`ifndef ARB_ROUND_ROBIN_EN
  logic last_grant_unused_s;
  assign last_grant_unused_s = last_grant;
`endif

  // Winner select; a lone requester always wins.
  always_comb begin
    any_req = ic_req | dc_req;
    grant   = GNT_IC;
    if (ic_req && dc_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant = (last_grant == GNT_IC) ? GNT_DC : GNT_IC;
`else
      grant = GNT_DC;
`endif
    end else if (dc_req) begin
      grant = GNT_DC;
    end else begin
      grant = GNT_IC;
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares the single 256-bit line-fill memory port between L1 icache and dcache, one transaction at a time.
// Build option: ARB_ROUND_ROBIN_EN (round-robin tie breaking instead of fixed dcache priority).
module l1_mem_arbiter
  import l1_mem_arbiter_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0] ic_data,
  output logic              ic_valid,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic              busy
);

  logic [1:0] state_r;
  logic       grant_r;
  logic       last_grant_r;
  logic       pick_any_s;
  logic       pick_grant_s;

  l1_mem_arbiter_arb_pick u_pick (
    .ic_req     (ic_req),
    .dc_req     (dc_req),
    .last_grant (last_grant_r),
    .any_req    (pick_any_s),
    .grant      (pick_grant_s)
  );

  // Transaction FSM; all outputs are registered here. Valid pulses coincide with the RESP cycle.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r      <= ARB_IDLE;
      grant_r      <= GNT_IC;
      last_grant_r <= GNT_IC;
      ic_data      <= {LINE_W{1'b0}};
      ic_valid     <= 1'b0;
      dc_rdata     <= {LINE_W{1'b0}};
      dc_valid     <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_address  <= {ADDR_W{1'b0}};
      mem_wdata    <= {LINE_W{1'b0}};
      busy         <= 1'b0;
    end else begin
      ic_valid <= 1'b0;
      dc_valid <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          if (pick_any_s) begin
            grant_r <= pick_grant_s;
            mem_req <= 1'b1;
            busy    <= 1'b1;
            state_r <= ARB_MEM_WAIT;
            if (pick_grant_s == GNT_DC) begin
              mem_we      <= dc_we;
              mem_address <= line_align(dc_addr);
              mem_wdata   <= dc_wdata;
            end else begin
              mem_we      <= 1'b0;
              mem_address <= line_align(ic_addr);
              mem_wdata   <= {LINE_W{1'b0}};
            end
          end
        end
        ARB_MEM_WAIT: begin
          if (mem_valid) begin
            mem_req <= 1'b0;
            state_r <= ARB_RESP;
            if (grant_r == GNT_IC) begin
              ic_data  <= mem_data;
              ic_valid <= 1'b1;
            end else begin
              dc_valid <= 1'b1;
              // A write-back completes without disturbing the last delivered read line.
              if (!mem_we) begin
                dc_rdata <= mem_data;
              end
            end
          end
        end
        ARB_RESP: begin
          last_grant_r <= grant_r;
          busy         <= 1'b0;
          state_r      <= ARB_IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (winner rule, aligned address, delivered lines).
module tb_l1_mem_arbiter;

  localparam int GIC = 0;
  localparam int GDC = 1;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         ic_req;
  logic [31:0]  ic_addr;
  logic [255:0] ic_data;
  logic         ic_valid;
  logic         dc_req;
  logic         dc_we;
  logic [31:0]  dc_addr;
  logic [255:0] dc_wdata;
  logic [255:0] dc_rdata;
  logic         dc_valid;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_data;
  logic         mem_valid;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit           ic_pend;
  bit           dc_pend;
  int           last_m;
  logic [255:0] ic_line_m;
  logic [255:0] dc_line_m;

  l1_mem_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_data(ic_data), .ic_valid(ic_valid),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_valid(dc_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_data(mem_data), .mem_valid(mem_valid), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int pick_m();
    if (ic_pend && dc_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (last_m == GIC) ? GDC : GIC;
`else
      return GDC;
`endif
    end
    return dc_pend ? GDC : GIC;
  endfunction

  task automatic model_reset();
    ic_pend   = 1'b0;
    dc_pend   = 1'b0;
    last_m    = GIC;
    ic_line_m = '0;
    dc_line_m = '0;
  endtask

  task automatic raise_ic(input logic [31:0] a);
    ic_addr = a;
    ic_req  = 1'b1;
    ic_pend = 1'b1;
  endtask

  task automatic raise_dc(input logic we, input logic [31:0] a, input logic [255:0] wd);
    dc_we    = we;
    dc_addr  = a;
    dc_wdata = wd;
    dc_req   = 1'b1;
    dc_pend  = 1'b1;
  endtask

  // One complete transaction, entered and left at a negedge with the arbiter idle.
  task automatic run_txn(input int lat, input logic [255:0] rsp);
    int           w;
    logic [31:0]  ea;
    logic         ewe;
    w   = pick_m();
    ea  = ((w == GIC) ? ic_addr : dc_addr) & 32'hFFFF_FFE0;
    ewe = (w == GDC) ? dc_we : 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("req_rise", {mem_req, busy, ic_valid, dc_valid}, 4'b1100);
    chk("mem_address", mem_address, ea);
    chk("mem_we", mem_we, ewe);
    if (ewe) chk("mem_wdata", mem_wdata, dc_wdata);
    repeat (lat) begin @(posedge CLK); @(negedge CLK); end
    chk("req_hold", {mem_req, mem_address}, {1'b1, ea});
    mem_data  = rsp;
    mem_valid = 1'b1;
    @(posedge CLK); @(negedge CLK);
    mem_valid = 1'b0;
    mem_data  = rand_line();
    if (w == GIC) ic_line_m = rsp;
    else if (!ewe) dc_line_m = rsp;
    chk((w == GIC) ? "ic_pulse" : "dc_pulse", {ic_valid, dc_valid}, (w == GIC) ? 2'b10 : 2'b01);
    chk("ic_data", ic_data, ic_line_m);
    chk("dc_rdata", dc_rdata, dc_line_m);
    chk("resp_state", {mem_req, busy}, 2'b01);
    @(posedge CLK); @(negedge CLK);
    if (w == GIC) begin ic_req = 1'b0; ic_pend = 1'b0; end
    else begin dc_req = 1'b0; dc_pend = 1'b0; end
    last_m = w;
    chk("back_idle", {ic_valid, dc_valid, busy, mem_req}, 4'b0000);
  endtask

  initial begin
    RESET = 1'b0; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0;
    dc_addr = '0; dc_wdata = '0; mem_data = '0; mem_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_ctl", {mem_req, mem_we, busy, ic_valid, dc_valid}, 5'b00000);
    chk("reset_lines", {ic_data, dc_rdata, mem_address, mem_wdata} == '0, 1'b1);
    RESET = 1'b1;
    @(negedge CLK);

    // icache read, 8-cycle memory latency
    raise_ic(32'h0000_1234);
    run_txn(8, {8{32'hAAAA_AAAA}});
    chk("t1_line", ic_data, {8{32'hAAAA_AAAA}});

    // spurious completion while idle
    mem_data  = rand_line();
    mem_valid = 1'b1;
    @(posedge CLK); @(negedge CLK);
    mem_valid = 1'b0;
    chk("spur_ctl", {busy, mem_req, ic_valid, dc_valid}, 4'b0000);
    chk("spur_ic", ic_data, ic_line_m);
    chk("spur_dc", dc_rdata, dc_line_m);

    // dcache write-back
    raise_dc(1'b1, 32'h0000_8040, {8{32'h5555_5555}});
    run_txn(3, rand_line());

    // simultaneous requests; dcache re-requests right after its first win
    raise_ic($urandom);
    raise_dc(1'b0, $urandom, rand_line());
    run_txn(2, rand_line());
    raise_dc(1'b0, $urandom, rand_line());
    run_txn(1, rand_line());
    run_txn(4, rand_line());

    // reset in the middle of a transaction, then a late completion
    raise_ic(32'h0000_2000);
    @(posedge CLK); @(negedge CLK);
    chk("t4_req", mem_req, 1'b1);
    @(posedge CLK); @(negedge CLK);
    RESET  = 1'b0;
    ic_req = 1'b0;
    model_reset();
    @(posedge CLK); @(negedge CLK);
    chk("t4_rst", {mem_req, busy, ic_valid, dc_valid}, 4'b0000);
    chk("t4_data", ic_data, ic_line_m);
    RESET     = 1'b1;
    mem_data  = rand_line();
    mem_valid = 1'b1;
    @(posedge CLK); @(negedge CLK);
    mem_valid = 1'b0;
    chk("t4_late", {mem_req, busy, ic_valid, dc_valid}, 4'b0000);
    @(posedge CLK); @(negedge CLK);
    chk("t4_quiet", {mem_req, busy, ic_valid, dc_valid}, 4'b0000);

    // first tie after reset
    raise_ic($urandom);
    raise_dc(1'b0, $urandom, rand_line());
    run_txn(0, rand_line());
    run_txn(2, rand_line());

    // dcache read held through its valid cycle: exactly one memory transaction
    raise_dc(1'b0, 32'h0000_C0DE, rand_line());
    run_txn(2, rand_line());
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); @(negedge CLK);
      chk("t6_single", {mem_req, busy}, 2'b00);
    end

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if (!ic_pend && $urandom_range(0, 1) == 1) raise_ic($urandom);
      if (!dc_pend && $urandom_range(0, 1) == 1) raise_dc($urandom_range(0, 1) == 1, $urandom, rand_line());
      if (!ic_pend && !dc_pend) raise_ic($urandom);
      run_txn($urandom_range(0, 5), rand_line());
    end
    while (ic_pend || dc_pend) run_txn(1, rand_line());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
